// File: rtl/rps_pkg.sv
// Shared types and helpers for the rotating-priority arbiter family.
package rps_pkg;

  typedef enum logic {
    RPS_ROTATE = 1'b0,
    RPS_RR     = 1'b1
  } rps_mode_e;

  localparam int RPS_MAX_N = 64;
  localparam int RPS_IDX_W = 6;

  // Callers zero-extend their one-hot vector and truncate the index to their width.
  function automatic logic [RPS_IDX_W-1:0] rps_oh2idx(input logic [RPS_MAX_N-1:0] oh);
    logic [RPS_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < RPS_MAX_N; i++) begin
      if (oh[i]) idx |= RPS_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rps_arb_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rps_arb_if #(parameter int N = 4);
  import rps_pkg::*;

  localparam int IW = $clog2(N);

  logic [N-1:0]  req;
  logic          en;
  rps_mode_e     mode;
  logic          lock;
  logic [N-1:0]  gnt;
  logic          gnt_valid;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] ptr;

  modport master (output req, en, mode, lock,
                  input  gnt, gnt_valid, gnt_idx, ptr);
  modport slave  (input  req, en, mode, lock,
                  output gnt, gnt_valid, gnt_idx, ptr);
endinterface

// File: rtl/rps_pick.sv
// Combinational rotating-priority search: first set req bit at or above ptr,
// falling back to the lowest set bit overall.
module rps_pick
  import rps_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  logic [N-1:0]           mask;
  logic [N-1:0]           masked;
  logic [N-1:0]           hi_gnt;
  logic [N-1:0]           lo_gnt;
  logic [RPS_MAX_N-1:0]   oh_ext;
  logic [RPS_IDX_W-1:0]   idx_full;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      mask[i] = (IW'(i) >= ptr);
    end
    masked = req & mask;
    // x & -x isolates the lowest set bit without a serial scan.
    hi_gnt = masked & (~masked + N'(1));
    lo_gnt = req & (~req + N'(1));
    gnt       = (|masked) ? hi_gnt : lo_gnt;
    gnt_valid = |req;
    oh_ext          = '0;
    oh_ext[N-1:0]   = gnt;
    idx_full        = rps_oh2idx(oh_ext);
    gnt_idx         = idx_full[IW-1:0];
  end

endmodule

// File: rtl/rps_arb.sv
// N-way rotating-priority arbiter with free-running or round-robin pointer
// and an optional grant lock.
module rps_arb
  import rps_pkg::*;
#(
  parameter int N = 4
) (
  input logic       clock,
  input logic       reset,
  rps_arb_if.slave  bus
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          held_vld_q, held_vld_d;
  logic [IW-1:0] held_idx_q, held_idx_d;

  logic [N-1:0]  pick_gnt;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;

  logic [N-1:0]  gnt;
  logic          gnt_valid;
  logic [IW-1:0] gnt_idx;

  rps_pick #(.N(N)) u_pick (
    .req       (bus.req),
    .ptr       (ptr_q),
    .gnt       (pick_gnt),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    if (bus.en) begin
      // A held requester that drops req falls straight through to the search.
      if (held_vld_q && bus.req[held_idx_q]) begin
        gnt[held_idx_q] = 1'b1;
        gnt_idx         = held_idx_q;
      end else if (pick_valid) begin
        gnt     = pick_gnt;
        gnt_idx = pick_idx;
      end
    end
    gnt_valid = |gnt;

    ptr_d = ptr_q;
    if (bus.mode == RPS_ROTATE) begin
      ptr_d = ptr_q + 1'b1;
    end else if (gnt_valid) begin
      ptr_d = gnt_idx + 1'b1;
    end

    held_vld_d = gnt_valid && bus.lock;
    held_idx_d = held_vld_d ? gnt_idx : held_idx_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q      <= '0;
      held_vld_q <= 1'b0;
      held_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      held_vld_q <= held_vld_d;
      held_idx_q <= held_idx_d;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.gnt_valid = gnt_valid;
  assign bus.gnt_idx   = gnt_idx;
  assign bus.ptr       = ptr_q;

  a_gnt_onehot0: assert property (@(posedge clock) $onehot0(gnt));
  a_gnt_valid:   assert property (@(posedge clock) gnt_valid == (|gnt));
  a_gnt_subset:  assert property (@(posedge clock) (gnt & ~bus.req) == '0);

endmodule

// File: doc/rps_arb.md
# rps_arb

Parametrised N-way rotating-priority arbiter; next generation of the team's 2/4-way rotating priority selectors. Accepts N request lines, issues at most one one-hot grant per cycle and keeps a registered priority pointer. The pointer either free-runs (legacy rotate mode) or advances past the last winner (true round-robin). An optional lock keeps a grant with one requester across multiple cycles. Sits in front of any shared resource: bus port, memory bank or functional unit.

## Interface
- N, default 4: number of requesters; power of two, ≥2.
- IW, default $clog2(N): index width; derived, not overridden.
- clock  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high.
- req  input  N  request vector; bit i = requester i.
- en  input  1  arbitration enable; 0 suppresses all grants.
- mode  input  1  RPS_ROTATE (0): pointer free-runs. RPS_RR (1): pointer follows the winner.
- lock  input  1  a grant issued in a cycle with lock=1 is held for following cycles.
- gnt  output  N  one-hot grant, or all zero.
- gnt_valid  output  1  |gnt.
- gnt_idx  output  IW  index of the granted bit; 0 when gnt_valid=0.
- ptr  output  IW  current highest-priority index (registered).

## Operation
- State is ptr[IW-1:0], held_vld and held_idx[IW-1:0].
- Grant is combinational from req, en and state, evaluated in this order:
  - en=0 → gnt=0.
  - held_vld && req[held_idx] → gnt=onehot(held_idx), ignoring priority.
  - otherwise the rotating search: the first set req bit scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - no set req bit → gnt=0.
- Pointer update at each edge:
  - RPS_ROTATE: ptr ← ptr+1 every cycle, independent of req and en; N-1 wraps to 0.
  - RPS_RR: if gnt_valid, ptr ← gnt_idx+1 mod N; otherwise ptr holds.
  - The RR rule also applies to held grants.
- Lock update at each edge:
  - gnt_valid && lock → held_vld←1, held_idx←gnt_idx.
  - otherwise held_vld←0.
  - A held requester that drops req loses the grant combinationally in that same cycle; the search then runs from ptr.
- en=0 leaves ptr behaviour per mode and clears held_vld, because no grant is issued.
- A mode change takes effect on the next pointer update; ptr is not reset.
- Reset values:
  - ptr=0, held_vld=0, held_idx=0.
  - Outputs during and after reset are pure functions of req/en with ptr=0.
  - Reset has priority over every update, including mid-lock.

## Timing
- Grant latency: 0 cycles. gnt, gnt_valid and gnt_idx are combinational from req/en in the same cycle.
- ptr and the lock state change only at the rising edge; the new priority applies from the following cycle.
- The critical path is the rotating search. The implementation uses the doubled-vector mask technique (req masked at ≥ptr, then unmasked fallback), with no N-deep ripple chain.
- Only one grant is active per cycle; gnt_valid=0 implies gnt_idx=0.

## Structure
- Package rps_pkg holds:
  - typedef enum logic {RPS_ROTATE, RPS_RR} rps_mode_e;
  - a onehot-to-index function shared with the encoder.
- Sub-module rps_pick (combinational, parameter N) contains the rotating-priority search: inputs req and ptr; outputs gnt, gnt_valid and gnt_idx.
- rps_arb contains the held-grant override, the en gating, the pointer and lock registers, and the mode mux.
- Assertions to include:
  - $onehot0(gnt).
  - gnt_valid == |gnt.
  - gnt is a subset of req.

## Test plan
All scenarios use N=4 unless noted.
- Fair rotation, RPS_RR: reset, then en=1, req=1111 for 5 cycles → gnt 0001, 0010, 0100, 1000, 0001; ptr 0, 1, 2, 3, 0.
- Legacy rotate: RPS_ROTATE, req=1010 constant from reset → ptr 0, 1, 2, 3, 0; gnt 0010, 0010, 1000, 1000, 0010.
- Enable gating: RPS_RR with ptr=2, req=1111, en=0 for 3 cycles → gnt=0000, gnt_valid=0, ptr stays 2; en=1 → gnt=0100.
- Lock hold and release: RPS_RR, req=1111, lock=1 while 0001 is granted → gnt stays 0001 for 4 cycles with ptr=1. Drop req[0] → gnt=0010 in the same cycle. lock=0 thereafter → normal rotation.
- Reset mid-lock: lock held on idx 2, ptr=3, assert reset for 1 cycle with req=1111 → next cycle ptr=0, held_vld=0, gnt=0001.
- Idle and wrap: N=8, RPS_RR, req=1000_0000 → gnt_idx=7 and ptr wraps to 0. Then req=0 → gnt=0, ptr holds 0. Same req=0 in RPS_ROTATE → ptr advances each cycle.
